// File: rtl/mc_control_unit_if.sv
// ---------------------------------------------------------------------------
// mc_control_unit_if
// Control bundle between the multi-cycle controller and the datapath.
//   master : the controller. It reads the instruction fields (opcode, funct3,
//            funct7b5) and the ALU flags, and drives ALUcntrl, the operand and
//            result selects, ImmSrc, AdrSrc, the write enables and illegal.
//   slave  : the datapath side, with the opposite directions.
// ---------------------------------------------------------------------------
interface mc_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zeroflag;
    logic       signflag;
    logic       carryflag;

    logic [2:0] ALUcntrl;
    logic [1:0] ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic       AdrSrc;
    logic       IRwrite;
    logic       PCwrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7b5, zeroflag, signflag, carryflag,
        output ALUcntrl, ALUsrcA, ALUsrcB, ResultSrc, ImmSrc, AdrSrc,
               IRwrite, PCwrite, MemWrite, RegWrite, illegal
    );

    modport slave (
        output opcode, funct3, funct7b5, zeroflag, signflag, carryflag,
        input  ALUcntrl, ALUsrcA, ALUsrcB, ResultSrc, ImmSrc, AdrSrc,
               IRwrite, PCwrite, MemWrite, RegWrite, illegal
    );
endinterface

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Moore FSM controlling the shared-ALU multi-cycle RV32I core. Decodes the
// IR fields into ALU operation, operand selects and register/memory enables,
// and resolves branches from the ALU flags.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; forces IRwrite/PCwrite/MemWrite/
//          RegWrite low while high and returns the FSM to FETCH
//   bus  - mc_control_unit_if.master (instruction fields and flags in,
//          control signals out)
// Optional build macro: BRANCH_EXT_EN adds blt/bge/bltu/bgeu resolution.
// ---------------------------------------------------------------------------
module mc_control_unit (
    input  logic              clk,
    input  logic              rst,
    mc_control_unit_if.master bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    typedef struct packed {
        logic [2:0] alucntrl;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       memwrite;
        logic       regwrite;
        logic       illegal;
    } ctl_t;

    state_t state;
    ctl_t   ctl;
    logic   taken;

    // Only R-type may turn funct3=000 into a subtract.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
        logic [2:0] op;
        op = 3'b000;
        case (f3)
            3'b000:  op = sub ? 3'b010 : 3'b000;
            3'b001:  op = 3'b001;
            3'b100:  op = 3'b100;
            3'b101:  op = 3'b101;   // sra is not supported and runs as srl
            3'b110:  op = 3'b110;
            3'b111:  op = 3'b111;
            default: op = 3'b000;
        endcase
        return op;
    endfunction

    function automatic state_t next_state(input state_t st, input logic [6:0] op,
                                          input logic [2:0] f3);
        state_t nx;
        nx = FETCH;
        case (st)
            FETCH:  nx = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nx = MEMADR;
                    OP_REG:            nx = (f3 == 3'b010 || f3 == 3'b011) ? TRAP : EXECR;
                    OP_IMM:            nx = (f3 == 3'b010 || f3 == 3'b011) ? TRAP : EXECI;
                    OP_BRANCH:         nx = BRANCH;
                    OP_JAL:            nx = JAL;
                    default:           nx = TRAP;
                endcase
            end
            MEMADR:   nx = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  nx = MEMWB;
            MEMWB:    nx = FETCH;
            MEMWRITE: nx = FETCH;
            EXECR:    nx = ALUWB;
            EXECI:    nx = ALUWB;
            ALUWB:    nx = FETCH;
            BRANCH:   nx = FETCH;
            JAL:      nx = ALUWB;   // ALUOut holds PC+4 for rd
            TRAP:     nx = TRAP;
            default:  nx = FETCH;
        endcase
        return nx;
    endfunction

    // Moore outputs of a state; the BRANCH PCwrite term is added separately.
    function automatic ctl_t moore_out(input state_t st, input logic [2:0] f3,
                                       input logic f7b5);
        ctl_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.pcwrite   = 1'b1;
                c.srcb      = 2'b10;
                c.resultsrc = 2'b10;
            end
            DECODE: begin
                c.srca = 2'b01;
                c.srcb = 2'b01;
            end
            MEMADR: begin
                c.srca = 2'b10;
                c.srcb = 2'b01;
            end
            MEMREAD:  c.adrsrc = 1'b1;
            MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECR: begin
                c.srca     = 2'b10;
                c.alucntrl = alu_decode(f3, f7b5);
            end
            EXECI: begin
                c.srca     = 2'b10;
                c.srcb     = 2'b01;
                c.alucntrl = alu_decode(f3, 1'b0);
            end
            ALUWB:    c.regwrite = 1'b1;
            BRANCH: begin
                c.srca     = 2'b10;
                c.alucntrl = 3'b010;
            end
            JAL: begin
                c.srca    = 2'b01;
                c.srcb    = 2'b10;
                c.pcwrite = 1'b1;
            end
            TRAP:     c.illegal = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Outputs are registered together with the state so they are glitch-free
    // for the whole cycle of the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            ctl   <= moore_out(FETCH, bus.funct3, bus.funct7b5);
        end else begin
            state <= next_state(state, bus.opcode, bus.funct3);
            ctl   <= moore_out(next_state(state, bus.opcode, bus.funct3),
                               bus.funct3, bus.funct7b5);
        end
    end

    // Branch decision from the flags of the compare running this cycle.
    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.zeroflag;
            3'b001:  taken = ~bus.zeroflag;
`ifdef BRANCH_EXT_EN
            3'b100:  taken = bus.signflag;
            3'b101:  taken = ~bus.signflag;
            3'b110:  taken = bus.carryflag;
            3'b111:  taken = ~bus.carryflag;
`endif
            default: taken = 1'b0;
        endcase
    end

`ifndef BRANCH_EXT_EN
    logic unused_flags;
    assign unused_flags = bus.signflag ^ bus.carryflag;
`endif

    always_comb begin
        bus.ImmSrc = 2'b00;
        case (bus.opcode)
            OP_LOAD, OP_IMM: bus.ImmSrc = 2'b00;
            OP_STORE:        bus.ImmSrc = 2'b01;
            OP_BRANCH:       bus.ImmSrc = 2'b10;
            OP_JAL:          bus.ImmSrc = 2'b11;
            default:         bus.ImmSrc = 2'b00;
        endcase
    end

    assign bus.ALUcntrl  = ctl.alucntrl;
    assign bus.ALUsrcA   = ctl.srca;
    assign bus.ALUsrcB   = ctl.srcb;
    assign bus.ResultSrc = ctl.resultsrc;
    assign bus.AdrSrc    = ctl.adrsrc;
    assign bus.illegal   = ctl.illegal;
    // Enables are held off for as long as reset is asserted.
    assign bus.IRwrite   = ctl.irwrite  & ~rst;
    assign bus.MemWrite  = ctl.memwrite & ~rst;
    assign bus.RegWrite  = ctl.regwrite & ~rst;
    assign bus.PCwrite   = (ctl.pcwrite | ((state == BRANCH) & taken)) & ~rst;
endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_control_unit_if bus();
    mc_control_unit dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef BRANCH_EXT_EN
    localparam logic EXT = 1'b1;
`else
    localparam logic EXT = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] alu;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       ill;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       s;
        logic       c;
        int         cycles;   // -1: take the length from the model
        logic       br;       // check PCwrite in cycle 3
        logic       taken;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    ctl_t exp_q[$];
    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic ctl_t mk(input logic [2:0] alu, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] res, input logic adr, input logic irw,
                                input logic pcw, input logic memw, input logic regw,
                                input logic ill);
        return {alu, a, b, res, adr, irw, pcw, memw, regw, ill};
    endfunction

    function automatic ctl_t actual();
        return {bus.ALUcntrl, bus.ALUsrcA, bus.ALUsrcB, bus.ResultSrc, bus.AdrSrc,
                bus.IRwrite, bus.PCwrite, bus.MemWrite, bus.RegWrite, bus.illegal};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == 7'b0000011 || op == 7'b0010011) return 2'b00;
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        logic [2:0] tbl [8];
        tbl = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
        if (f3 == 3'b000 && sub) return 3'b010;
        return tbl[f3];
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic s,
                                      input logic c);
        if (f3 == 3'b000) return z;
        if (f3 == 3'b001) return !z;
        if (EXT && f3 == 3'b100) return s;
        if (EXT && f3 == 3'b101) return !s;
        if (EXT && f3 == 3'b110) return c;
        if (EXT && f3 == 3'b111) return !c;
        return 1'b0;
    endfunction

    // Per-cycle expected outputs of one complete instruction, FETCH first.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic s, input logic c);
        ctl_t wb;
        wb = mk(3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        exp_q.delete();
        exp_q.push_back(mk(3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        exp_q.push_back(mk(3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        case (op)
            7'b0000011: begin
                exp_q.push_back(mk(3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0));
            end
            7'b0100011: begin
                exp_q.push_back(mk(3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0));
            end
            7'b0110011: begin
                exp_q.push_back(mk(alu_of(f3, f7), 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(wb);
            end
            7'b0010011: begin
                exp_q.push_back(mk(alu_of(f3, 1'b0), 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
                exp_q.push_back(wb);
            end
            7'b1100011:
                exp_q.push_back(mk(3'b010, 2'b10, 2'b00, 2'b00, 0, 0,
                                   br_taken(f3, z, s, c), 0, 0, 0));
            7'b1101111: begin
                exp_q.push_back(mk(3'b000, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0));
                exp_q.push_back(wb);
            end
            default: exp_q.push_back(mk(3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
        endcase
    endtask

    // Called 1 time unit after the negedge of a FETCH cycle; returns at the
    // same point of the following FETCH cycle.
    task automatic run_instr(input vec_t v, input string tag);
        int  k;
        int  need;
        bit  done;
        bus.opcode   = v.op;
        bus.funct3   = v.f3;
        bus.funct7b5 = v.f7;
        bus.zeroflag = v.z;
        bus.signflag = v.s;
        bus.carryflag = v.c;
        #1;
        build(v.op, v.f3, v.f7, v.z, v.s, v.c);
        need = (v.cycles < 0) ? exp_q.size() : v.cycles;
        k = 0;
        done = 0;
        while (!done) begin
            if (k > 0 && bus.IRwrite === 1'b1) begin
                done = 1;
            end else if (k >= 12) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: no FETCH after %0d cycles", tag, k);
                done = 1;
            end else begin
                if (k < exp_q.size())
                    check($sformatf("%s ctl c%0d", tag, k), actual(), exp_q[k]);
                check($sformatf("%s imm c%0d", tag, k), bus.ImmSrc, imm_of(v.op));
                if (v.br && k == 2)
                    check($sformatf("%s taken", tag), bus.PCwrite, v.taken);
                @(negedge clk);
                #1;
                k++;
            end
        end
        check($sformatf("%s cycles", tag), k, need);
    endtask

    task automatic check_enables_off(input string tag);
        check(tag, {bus.IRwrite, bus.PCwrite, bus.MemWrite, bus.RegWrite}, 4'b0000);
    endtask

    task automatic trap_seq(input logic [6:0] op, input logic [2:0] f3, input int hold,
                            input string tag);
        ctl_t trap_c;
        trap_c = mk(3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7b5 = 1'b0;
        #1;
        build(op, f3, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, " fetch"}, actual(), exp_q[0]);
        @(negedge clk); #1;
        check({tag, " decode"}, actual(), exp_q[1]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check($sformatf("%s trap c%0d", tag, i), actual(), trap_c);
            check($sformatf("%s trap imm c%0d", tag, i), bus.ImmSrc, imm_of(op));
        end
        rst = 1'b1;
        @(negedge clk); #1;
        check({tag, " rst illegal"}, bus.illegal, 1'b0);
        check_enables_off({tag, " rst enables"});
        rst = 1'b0;
        #1;
        check({tag, " refetch"}, actual(), mk(3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
    endtask

    initial begin
        logic [6:0] legal_ops [6];
        vec_t rv;
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

        //            op           f3      f7 z  s  c  cyc br taken
        vecs[0]  = '{7'b0110011, 3'b000, 0, 0, 0, 0, 4, 0, 0};   // add
        vecs[1]  = '{7'b0110011, 3'b000, 1, 0, 0, 0, 4, 0, 0};   // sub
        vecs[2]  = '{7'b0010011, 3'b000, 1, 0, 0, 0, 4, 0, 0};   // addi, f7b5 ignored
        vecs[3]  = '{7'b0110011, 3'b001, 0, 0, 0, 0, 4, 0, 0};   // sll
        vecs[4]  = '{7'b0010011, 3'b100, 0, 0, 0, 0, 4, 0, 0};   // xori
        vecs[5]  = '{7'b0110011, 3'b101, 1, 0, 0, 0, 4, 0, 0};   // sra -> srl
        vecs[6]  = '{7'b0010011, 3'b110, 0, 0, 0, 0, 4, 0, 0};   // ori
        vecs[7]  = '{7'b0110011, 3'b111, 0, 0, 0, 0, 4, 0, 0};   // and
        vecs[8]  = '{7'b0000011, 3'b010, 0, 0, 0, 0, 5, 0, 0};   // lw
        vecs[9]  = '{7'b0100011, 3'b010, 0, 0, 0, 0, 4, 0, 0};   // sw
        vecs[10] = '{7'b1100011, 3'b000, 0, 1, 0, 0, 3, 1, 1};   // beq taken
        vecs[11] = '{7'b1100011, 3'b000, 0, 0, 1, 1, 3, 1, 0};   // beq not taken
        vecs[12] = '{7'b1100011, 3'b001, 0, 1, 0, 0, 3, 1, 0};   // bne not taken
        vecs[13] = '{7'b1100011, 3'b001, 0, 0, 0, 0, 3, 1, 1};   // bne taken
        vecs[14] = '{7'b1100011, 3'b110, 0, 0, 0, 1, 3, 1, EXT}; // bltu carry=1
        vecs[15] = '{7'b1100011, 3'b101, 0, 0, 1, 0, 3, 1, 0};   // bge sign=1
        vecs[16] = '{7'b1100011, 3'b100, 0, 0, 1, 0, 3, 1, EXT}; // blt sign=1
        vecs[17] = '{7'b1100011, 3'b111, 0, 1, 1, 0, 3, 1, EXT}; // bgeu carry=0
        vecs[18] = '{7'b1100011, 3'b010, 0, 1, 1, 1, 3, 1, 0};   // funct3 010 never taken
        vecs[19] = '{7'b1101111, 3'b000, 0, 0, 0, 0, 4, 0, 0};   // jal

        rst = 1'b1;
        bus.opcode = 7'b0100011;
        bus.funct3 = 3'b010;
        bus.funct7b5 = 1'b0;
        bus.zeroflag = 1'b0;
        bus.signflag = 1'b0;
        bus.carryflag = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_enables_off("reset enables");
        check("reset illegal", bus.illegal, 1'b0);
        rst = 1'b0;
        #1;
        check("first fetch", actual(), mk(3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));

        foreach (vecs[i]) run_instr(vecs[i], $sformatf("vec%0d", i));

        // Reset in MEMADR of a store: the MemWrite cycle must never happen.
        bus.opcode = 7'b0100011;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_enables_off("midrst c0");
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk); #1;
            check_enables_off($sformatf("midrst c%0d", i));
        end
        rst = 1'b0;
        #1;
        check("midrst fetch", actual(), mk(3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));

        for (int n = 0; n < 40; n++) begin
            rv.op = legal_ops[$urandom_range(0, 5)];
            rv.f3 = 3'($urandom_range(0, 7));
            if ((rv.op == 7'b0110011 || rv.op == 7'b0010011) && rv.f3[2:1] == 2'b01)
                rv.f3[2] = 1'b1;
            rv.f7 = 1'($urandom_range(0, 1));
            rv.z  = 1'($urandom_range(0, 1));
            rv.s  = 1'($urandom_range(0, 1));
            rv.c  = 1'($urandom_range(0, 1));
            rv.cycles = -1;
            rv.br = 1'b0;
            rv.taken = 1'b0;
            run_instr(rv, $sformatf("rnd%0d", n));
        end

        trap_seq(7'b1110011, 3'b000, 10, "ecall");
        trap_seq(7'b0110011, 3'b010, 3, "slt");
        trap_seq(7'b0010011, 3'b011, 3, "sltiu");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle controller that drives the ALU's control interface: decodes RV32I instruction fields into ALUcntrl and datapath enables, and consumes the ALU's zeroflag/signflag/carryflag for branch resolution. It is the Moore FSM for the team's multi-cycle core variant, which shares one ALU for PC increment, address generation, execution and branch compare. Datapath registers (PC, IR, OldPC, ALUOut, Data) live outside this block.

## Interface
Parameters: none.

- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- opcode  input  7  IR[6:0]
- funct3  input  3  IR[14:12]
- funct7b5  input  1  IR[30]
- zeroflag, signflag, carryflag  input  1 each  ALU flags, same cycle as ALUcntrl
- ALUcntrl  output  3  000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and
- ALUsrcA  output  2  00 PC, 01 OldPC, 10 rs1
- ALUsrcB  output  2  00 rs2, 01 imm, 10 constant 4
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUrslt direct
- ImmSrc  output  2  combinational from opcode: I 00, S 01, B 10, J 11
- AdrSrc  output  1  0 PC, 1 Result
- IRwrite, PCwrite, MemWrite, RegWrite  output  1 each  register/memory enables
- illegal  output  1  high in TRAP

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Outputs are Moore outputs, except PCwrite in BRANCH. Unlisted outputs are 0. ALUcntrl defaults to 000.
- FETCH: IRwrite=1, PCwrite=1, AdrSrc=0, A=00, B=10, add, ResultSrc=10. Transition -> DECODE.
- DECODE: A=01, B=01, add (branch target into ALUOut). Transition on opcode:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> TRAP
  - funct3 010/011 (slt/sltu) on R/I-type -> TRAP.
- MEMADR: A=10, B=01, add. Transition -> MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Transition -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Transition -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Transition -> FETCH.
- EXECR: A=10, B=00, ALUcntrl decoded. Transition -> ALUWB.
- EXECI: A=10, B=01, ALUcntrl decoded. Transition -> ALUWB.
- ALU decode by funct3:
  - 000: add; sub only when EXECR and funct7b5=1
  - 001: sll
  - 100: xor
  - 101: srl (funct7b5 ignored; sra unsupported, executes as srl)
  - 110: or
  - 111: and
- ALUWB: ResultSrc=00, RegWrite=1. Transition -> FETCH.
- BRANCH: A=10, B=00, sub, ResultSrc=00, PCwrite=taken. Transition -> FETCH.
  - beq (000): taken=zeroflag
  - bne (001): taken=~zeroflag
- JAL: A=01, B=10, add, ResultSrc=00, PCwrite=1 (target from DECODE). Transition -> ALUWB (rd=PC+4).
- TRAP: illegal=1, all enables 0. Sticky until rst.

## Timing
- Reset: rst high at a rising edge puts the state in FETCH. While rst is high, IRwrite, PCwrite, MemWrite and RegWrite are forced to 0. First fetch occurs on the first edge with rst low.
- Reset mid-instruction aborts the instruction; no enable asserts after the reset edge.
- Cycle counts, including FETCH:
  - lw 5
  - sw 4
  - R/I-type 4
  - branch 3
  - jal 4
- Flags are sampled combinationally in BRANCH. The 33-bit ALU subtraction gives carryflag=1 when srcA<srcB unsigned (borrow).
- ImmSrc is a pure function of opcode in every state. For unknown opcodes it is 00.

## Configuration
- BRANCH_EXT_EN defined: BRANCH also resolves the following (signed compare uses flag only, no overflow correction):
  - blt (100): taken=signflag
  - bge (101): taken=~signflag
  - bltu (110): taken=carryflag
  - bgeu (111): taken=~carryflag
- Undefined: those funct3 values are never taken (PCwrite=0). Only beq/bne resolve. Funct3 010/011 in BRANCH are never taken in both builds.

## Test plan
- Reset: rst=1 for 2 cycles with MemWrite pattern pending -> all enables 0. First cycle after release is FETCH with IRwrite=1, PCwrite=1, ALUcntrl=000.
- add (opcode 0110011, funct3 000, funct7b5=0) then sub (funct7b5=1) -> EXECR ALUcntrl 000 then 010. RegWrite=1 only in 4th cycle.
- lw (0000011) -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB. AdrSrc=1 in MEMREAD, RegWrite=1 with ResultSrc=01 in cycle 5. sw asserts MemWrite exactly once in cycle 4.
- beq with zeroflag=1 -> PCwrite=1 in cycle 3. bne with zeroflag=1 -> PCwrite=0.
- BRANCH_EXT_EN: bltu with carryflag=1 -> taken; bge with signflag=1 -> not taken. Macro undefined: bltu with carryflag=1 -> PCwrite=0.
- opcode 1110011 -> TRAP, illegal=1 held 10 cycles, no enables. rst -> FETCH, illegal=0.
